// File: rtl/labfinal_soc_keycode_in_if.sv
// rtl/labfinal_soc_keycode_in_if.sv - Avalon-MM register bus between the CPU data master and the keycode-in slave
interface labfinal_soc_keycode_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/labfinal_soc_keycode_in.sv
// rtl/labfinal_soc_keycode_in.sv - keycode FIFO from hardware to the CPU with status, flush and pending-data interrupt
module labfinal_soc_keycode_in #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    labfinal_soc_keycode_in_if.slave      avs,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          in_ready,
    output logic                          irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  irq_en_q, irq_en_d;

    logic empty, full, wr_sel, pop, push, drop, flush, ovf_clr;
    logic [31:0] rdata;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign wr_sel = avs.chipselect & ~avs.write_n;
    assign flush  = wr_sel & (avs.address == 2'd2) & avs.writedata[1];
    assign ovf_clr = wr_sel & (avs.address == 2'd1) & avs.writedata[18];

    // Flush discards everything in flight, including a drop that would otherwise flag overflow.
    assign pop  = avs.chipselect & ~avs.read_n & (avs.address == 2'd0) & ~empty & ~flush;
    assign push = in_valid & ~full & ~flush;
    assign drop = in_valid & full & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        irq_en_d = irq_en_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        if (wr_sel && avs.address == 2'd2) irq_en_d = avs.writedata[0];
        // A drop in the same cycle as a CPU clear keeps overflow set.
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) mem_q[wr_ptr_q] <= in_data;
    end

    always_comb begin
        rdata = '0;
        case (avs.address)
            2'd0: if (!empty) rdata[DATA_WIDTH-1:0] = mem_q[rd_ptr_q];
            2'd1: begin
                rdata[CW-1:0] = count_q;
                rdata[16]     = empty;
                rdata[17]     = full;
                rdata[18]     = ovf_q;
            end
            2'd2: rdata[0] = irq_en_q;
            default: rdata = '0;
        endcase
    end

    assign avs.readdata = rdata;
    assign in_ready     = ~full;
    assign irq          = irq_en_q & (~empty | ovf_q);
endmodule

// File: tb/tb_labfinal_soc_keycode_in.sv
// tb/tb_labfinal_soc_keycode_in.sv - directed and randomized checks of the keycode-in FIFO against a queue model
module tb_labfinal_soc_keycode_in;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       irq;

    labfinal_soc_keycode_in_if bus ();

    labfinal_soc_keycode_in #(.DEPTH(16), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .avs      (bus.slave),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] q [$];
    bit m_ovf = 0;
    bit m_irq_en = 0;

    function automatic logic [31:0] exp_rdata(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: if (q.size() != 0) r = {24'b0, q[0]};
            2'd1: begin
                r = 32'(q.size());
                if (q.size() == 0)  r = r | 32'h0001_0000;
                if (q.size() == 16) r = r | 32'h0002_0000;
                if (m_ovf)          r = r | 32'h0004_0000;
            end
            2'd2: r = {31'b0, m_irq_en};
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        in_valid       = 1'b0;
        in_data        = '0;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
    endtask

    task automatic cyc(input bit pv, input logic [7:0] pd, input bit rd, input bit wr,
                       input logic [1:0] a, input logic [31:0] wd, input string tag);
        bit pre_full, flush;
        in_valid       = pv;
        in_data        = pd;
        bus.chipselect = rd | wr;
        bus.read_n     = ~rd;
        bus.write_n    = ~wr;
        bus.address    = a;
        bus.writedata  = wd;
        @(negedge clk);
        chk({tag, ".rdata"}, bus.readdata, exp_rdata(a));
        chk({tag, ".irq"}, {31'b0, irq}, {31'b0, m_irq_en && (q.size() != 0 || m_ovf)});
        chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, q.size() != 16});
        @(posedge clk);
        pre_full = (q.size() == 16);
        flush = wr && a == 2'd2 && wd[1];
        if (flush) begin
            q.delete();
        end else begin
            if (rd && a == 2'd0 && q.size() != 0) void'(q.pop_front());
            if (pv) begin
                if (pre_full) m_ovf = 1;
                else          q.push_back(pd);
            end
        end
        if (wr && a == 2'd1 && wd[18] && !(pv && pre_full && !flush)) m_ovf = 0;
        if (wr && a == 2'd2) m_irq_en = wd[0];
        #1;
        drive_idle();
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1, d, 0, 0, 2'd1, 32'h0, "push");
    endtask

    task automatic pop();
        cyc(0, 8'h0, 1, 0, 2'd0, 32'h0, "pop");
    endtask

    task automatic idle(input logic [1:0] a);
        cyc(0, 8'h0, 0, 0, a, 32'h0, "idle");
    endtask

    task automatic wreg(input logic [1:0] a, input logic [31:0] wd);
        cyc(0, 8'h0, 0, 1, a, wd, "wreg");
    endtask

    task automatic do_reset(input bit pending_traffic);
        reset_n = 1'b0;
        if (pending_traffic) begin
            in_valid       = 1'b1;
            in_data        = 8'h5A;
            bus.chipselect = 1'b1;
            bus.read_n     = 1'b0;
            bus.address    = 2'd0;
        end
        @(posedge clk);
        q.delete();
        m_ovf = 0;
        m_irq_en = 0;
        #1;
        reset_n = 1'b1;
        drive_idle();
    endtask

    initial begin
        int pushed;
        int guard;
        bit pv, rd;
        drive_idle();

        // Reset state
        do_reset(0);
        idle(2'd1);
        chk("reset.status", bus.readdata, 32'h0001_0000);
        idle(2'd0);
        idle(2'd2);

        // Basic ordering with back-to-back pops
        push(8'h1C);
        push(8'h32);
        push(8'h23);
        idle(2'd1);
        pop();
        pop();
        pop();
        idle(2'd1);

        // Fill, overflow, drain, clear overflow
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hAA);
        idle(2'd1);
        cyc(1, 8'hBB, 0, 1, 2'd1, 32'h0004_0000, "setwins");
        cyc(1, 8'hCC, 1, 0, 2'd0, 32'h0, "fullpushpop");
        idle(2'd1);
        for (int i = 0; i < 16; i++) pop();
        pop();
        idle(2'd1);
        wreg(2'd1, 32'h0004_0000);
        idle(2'd1);

        // Randomized wrap traffic with occupancy kept in 1..5
        pushed = 1;
        push(8'($urandom_range(0, 255)));
        guard = 0;
        while (!(pushed == 40 && q.size() == 1) && guard < 400) begin
            pv = (pushed < 40) && (q.size() < 5) && ($urandom_range(0, 1) == 1 || q.size() <= 1);
            rd = (q.size() > 1) && ($urandom_range(0, 1) == 1 || q.size() == 5 || pushed >= 40);
            if (pv) pushed++;
            cyc(pv, 8'($urandom_range(0, 255)), rd, 0, rd ? 2'd0 : 2'd1, 32'h0, "wrap");
            guard++;
        end
        chk("wrap.done", 32'(guard < 400), 32'd1);
        pop();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        cyc(1, 8'h44, 1, 0, 2'd0, 32'h0, "pushpop3");
        idle(2'd1);
        chk("pushpop3.count", bus.readdata, 32'h0000_0003);
        pop();
        pop();
        pop();
        cyc(1, 8'h55, 1, 0, 2'd0, 32'h0, "pushpop_empty");
        idle(2'd1);
        pop();

        // Interrupt behaviour
        wreg(2'd2, 32'h1);
        idle(2'd2);
        push(8'h2A);
        idle(2'd0);
        pop();
        idle(2'd1);
        for (int i = 0; i < 17; i++) push(8'($urandom_range(0, 255)));
        for (int i = 0; i < 16; i++) pop();
        idle(2'd1);
        wreg(2'd1, 32'h0004_0000);
        idle(2'd1);

        // Flush at count 5 with a same-cycle push, overflow preserved
        for (int i = 0; i < 17; i++) push(8'($urandom_range(0, 255)));
        for (int i = 0; i < 11; i++) pop();
        idle(2'd1);
        cyc(1, 8'h77, 0, 1, 2'd2, 32'h0000_0003, "flush");
        idle(2'd1);
        chk("flush.status", bus.readdata, 32'h0005_0000);
        idle(2'd2);

        // Reset mid-stream with traffic pending
        push(8'h01);
        push(8'h02);
        do_reset(1);
        idle(2'd1);
        chk("midreset.status", bus.readdata, 32'h0001_0000);
        idle(2'd0);
        idle(2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/labfinal_soc_keycode_in.md
# labfinal_soc_keycode_in

Avalon-MM slave that carries keycodes from hardware to the NIOS II, the CPU-bound direction of the keycode PIO path. A hardware source (USB/PS2 keyboard decoder) pushes 8-bit keycodes into an internal FIFO. The CPU pops them through register reads, polls occupancy and overflow status, and can take an interrupt when data is pending. It sits in the labfinal_soc Qsys system beside the output PIOs, on the same clock domain as the CPU data master.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..256.
- DATA_WIDTH, 8, keycode width; 1..8.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on clk rising edge.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon slave select.
- read_n  in  1  Avalon read strobe, active low.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; zero wait states, read latency 0.
- in_valid  in  1  hardware keycode strobe; one push attempt per cycle high.
- in_data  in  DATA_WIDTH  keycode presented with in_valid.
- in_ready  out  1  high when FIFO not full (advisory).
- irq  out  1  level interrupt to the CPU.

## Operation
- Register map, readdata combinational from address and current state; unused bits read 0:
  - addr 0 DATA: read returns head entry in [DATA_WIDTH-1:0], 0 when empty. Writes ignored.
  - addr 1 STATUS: [8:0] count (0..DEPTH), [16] empty, [17] full, [18] overflow (sticky). Writing 1 to bit 18 clears overflow; other bits ignored.
  - addr 2 CONTROL: [0] irq_en (R/W). Writing 1 to [1] flushes the FIFO; [1] always reads 0.
  - addr 3: reads 0, writes ignored.
- Pop: chipselect & ~read_n & address==0 & !empty at a clk edge. The read returns the head combinationally in the same cycle, and the read pointer advances at that edge. Read on empty: no pop, no error.
- Push: in_valid & !full at a clk edge writes in_data at the write pointer, which then advances.
- Drop: in_valid & full: the byte is discarded and overflow is set to 1. FIFO contents are unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop, FIFO neither empty nor full: both occur, count unchanged.
- Simultaneous push and pop, FIFO full: pop occurs. The push is dropped and overflow is set, because full is evaluated on pre-edge state. count becomes DEPTH-1.
- Simultaneous push and pop, FIFO empty: pop ignored, push occurs, count becomes 1.
- Flush: pointers and count go to 0. overflow and irq_en are unchanged. Flush has priority over a same-cycle push or pop: the push is discarded without setting overflow.
- Same-cycle overflow set (drop) and overflow clear (CPU write): set wins, overflow stays 1.
- irq = irq_en & (!empty | overflow). It is combinational from registered state, so it is glitch-free with respect to Avalon inputs.
- Reset (reset_n low at a clk edge): pointers 0, count 0, overflow 0, irq_en 0.
  - Outputs after reset: in_ready 1, irq 0, readdata at addr 1 = 0x0001_0000.
  - Reset overrides any push, pop or write in the same cycle.
  - Storage array contents need no reset.

## Timing
- Avalon: zero wait states, no waitrequest, one transfer per cycle. Back-to-back pops on consecutive cycles return consecutive entries.
- Push-to-visible latency: data pushed at edge N appears at DATA, in count, and on irq from cycle N+1.
- Pop/flush/CSR write updates take effect after the edge, visible at N+1.
- in_ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop or flush from full.
- No combinational path from in_valid or in_data to readdata, irq or in_ready.

## Test plan
- Reset, then read addr 1 -> 0x0001_0000. Read addr 0 -> 0. irq=0, in_ready=1.
- Push 0x1C, 0x32, 0x23, then read addr 0 three times on consecutive cycles -> 0x1C, 0x32, 0x23. Count goes 3 to 0, then empty=1.
- Push 16 bytes 0x00..0x0F, then push 0xAA -> full=1, overflow=1, in_ready=0. Pops return 0x00..0x0F and 0xAA never appears. Writing 0x0004_0000 to addr 1 clears overflow.
- Pointer wrap: push/pop 40 bytes keeping occupancy 1..5 -> data order preserved across wrap, count correct. Simultaneous push+pop at count 3 keeps count 3.
- Enable irq (write 1 to addr 2): empty -> irq 0; one push -> irq 1 next cycle; pop it -> irq 0. With overflow set and FIFO empty -> irq 1 until overflow cleared.
- Flush with a same-cycle push at count 5 -> count 0, overflow unchanged. Assert reset_n low mid-stream with a pop pending -> all state returns to reset values next cycle.
